// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision result path.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned FLAG_W = 5;

    localparam int unsigned FLG_INV = 4;
    localparam int unsigned FLG_OVF = 3;
    localparam int unsigned FLG_UNF = 2;
    localparam int unsigned FLG_INX = 1;
    localparam int unsigned FLG_ZER = 0;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    typedef logic [FLAG_W-1:0] fp_flags_t;

    typedef struct packed {
        fp_word_t  word;
        fp_flags_t flags;
    } fp_entry_t;

    localparam int unsigned ENTRY_W = $bits(fp_entry_t);

    function automatic logic is_nan(input fp_word_t w);
        return (w.exp == '1) && (w.man != '0);
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Generic synchronous FIFO with occupancy counter; reads 0 when empty.
module fp_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Packs add/sub core results into IEEE-754 words, queues them, and tracks sticky flags and a pop counter.
// Optional: define RESULT_CANON_NAN_EN to store every NaN as the canonical quiet NaN.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Sz,
    input  logic [EXP_W-1:0]  Ez,
    input  logic [MAN_W-1:0]  Mz,
    input  logic              invalid_flag,
    input  logic              overflow_flag,
    input  logic              underflow_flag,
    input  logic              inexact_flag,
    input  logic              zero_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              flags_clr,
    output logic [CNT_W-1:0]  result_cnt
);

`ifdef RESULT_CANON_NAN_EN
    localparam bit CANON_EN = 1'b1;
`else
    localparam bit CANON_EN = 1'b0;
`endif

    fp_word_t  raw_word;
    fp_flags_t in_flags;
    fp_entry_t wr_entry;
    fp_entry_t rd_entry;
    logic      push;
    logic      pop;

    always_comb begin
        raw_word          = '0;
        raw_word.sign     = Sz;
        raw_word.exp      = Ez;
        raw_word.man      = Mz;
        in_flags          = '0;
        in_flags[FLG_INV] = invalid_flag;
        in_flags[FLG_OVF] = overflow_flag;
        in_flags[FLG_UNF] = underflow_flag;
        in_flags[FLG_INX] = inexact_flag;
        in_flags[FLG_ZER] = zero_flag;
        wr_entry.flags    = in_flags;
        wr_entry.word     = (CANON_EN && is_nan(raw_word)) ? fp_word_t'(CANON_QNAN) : raw_word;
    end

    fp_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (wr_entry),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (rd_entry)
    );

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = rd_entry.word;
    assign out_flags = rd_entry.flags;

    // Clear wins over accumulation, but a same-cycle push still lands its flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sticky_flags <= '0;
        end else if (flags_clr) begin
            sticky_flags <= push ? in_flags : '0;
        end else if (push) begin
            sticky_flags <= sticky_flags | in_flags;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            result_cnt <= '0;
        end else if (pop) begin
            result_cnt <= result_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_result_collector.sv
// Scoreboard bench for fp_result_collector: stimulus enqueues expected words, a monitor checks pops.
module tb_fp_result_collector;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        Sz;
    logic [7:0]  Ez;
    logic [22:0] Mz;
    logic        invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        flags_clr;
    logic [15:0] result_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    fp_result_collector dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .Sz             (Sz),
        .Ez             (Ez),
        .Mz             (Mz),
        .invalid_flag   (invalid_flag),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag),
        .inexact_flag   (inexact_flag),
        .zero_flag      (zero_flag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_flags      (out_flags),
        .sticky_flags   (sticky_flags),
        .flags_clr      (flags_clr),
        .result_cnt     (result_cnt)
    );

    // Monitor: every handshake about to complete must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pop: got data=%h flags=%b, required no output", out_data, out_flags);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_flags !== mon_e.flags) begin
                    miscompares++;
                    $display("FAIL pop_data: got data=%h flags=%b, required data=%h flags=%b",
                             out_data, out_flags, mon_e.data, mon_e.flags);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                         input logic [4:0] f, input logic [31:0] want, input bit acc);
        in_valid = 1'b1;
        Sz = s;
        Ez = e;
        Mz = m;
        {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} = f;
        if (acc) exp_q.push_back(exp_t'({want, f}));
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] nan_want;
    logic [7:0]  se;
    logic [22:0] sm;
    logic [4:0]  sf;

    initial begin
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        Sz = 1'b0; Ez = '0; Mz = '0;
        {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} = '0;
        tick(); tick();
        RST = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_flags", 32'(out_flags), 32'h0);
        check("rst_sticky", 32'(sticky_flags), 32'h0);
        check("rst_result_cnt", 32'(result_cnt), 32'h0);

        // Single result, one-cycle latency.
        out_ready = 1'b1;
        drive(1'b0, 8'h82, 23'h1C0000, 5'b00000, 32'h411C0000, 1'b1);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        tick();
        check("cnt_after_one", 32'(result_cnt), 32'd1);

        // Fill to DEPTH, fifth push dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h80 + 8'(i), 23'(i), 5'b00000, {1'b0, 8'h80 + 8'(i), 23'(i)}, 1'b1);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h55, 23'h7FFFFF, 5'b00000, 32'hAAFFFFFF, 1'b0);
        check("full_in_ready_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("drained_out_valid", 32'(out_valid), 32'd0);
        check("cnt_after_drain", 32'(result_cnt), 32'd5);

        // Sticky accumulation and clear priority.
        drive(1'b0, 8'hFF, 23'h0, 5'b01000, 32'h7F800000, 1'b1);
        drive(1'b0, 8'h7F, 23'h0, 5'b00010, 32'h3F800000, 1'b1);
        check("sticky_or", 32'(sticky_flags), 32'b01010);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("sticky_clr", 32'(sticky_flags), 32'b00000);
        flags_clr = 1'b1;
        drive(1'b1, 8'h81, 23'h0, 5'b10000, 32'hC0800000, 1'b1);
        flags_clr = 1'b0;
        check("sticky_clr_push", 32'(sticky_flags), 32'b10000);

        // NaN payload handling.
`ifdef RESULT_CANON_NAN_EN
        nan_want = 32'h7FC00000;
`else
        nan_want = 32'h7F800208;
`endif
        drive(1'b0, 8'hFF, 23'h000208, 5'b10000, nan_want, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-transfer with in_valid high.
        out_ready = 1'b0;
        drive(1'b0, 8'h01, 23'h1, 5'b00001, 32'h0, 1'b0);
        drive(1'b0, 8'h02, 23'h2, 5'b00100, 32'h0, 1'b0);
        check("pre_rst_sticky", 32'(sticky_flags), 32'b10101);
        RST = 1'b1;
        in_valid = 1'b1; Ez = 8'h03; Mz = 23'h3;
        {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} = 5'b11111;
        tick();
        RST = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
        check("mid_rst_out_data", out_data, 32'h0);
        check("mid_rst_sticky", 32'(sticky_flags), 32'h0);
        check("mid_rst_cnt", 32'(result_cnt), 32'h0);
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Half full, then 20 cycles of simultaneous push and pop.
        drive(1'b0, 8'hA0, 23'h0000AA, 5'b00001, 32'h500000AA, 1'b1);
        drive(1'b1, 8'hA1, 23'h0000BB, 5'b00010, 32'hD08000BB, 1'b1);
        check("half_count", 32'(dut.u_fifo.count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            se = 8'h10 + 8'(i);
            sm = 23'(i * 256 + 7);
            sf = 5'(i);
            drive(1'(i), se, sm, sf, {1'(i), se, sm}, 1'b1);
            check("stream_count", 32'(dut.u_fifo.count), 32'd2);
        end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        tick();
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("stream_result_cnt", 32'(result_cnt), 32'd22);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
Sequential result-side companion to the combinational add/sub datapath. It captures the unpacked result (sign, exponent, mantissa) and the five exception flags from the core, and packs them into an IEEE-754 single-precision word. Results are queued in a small FIFO and delivered to the consumer over a valid/ready handshake. The block also keeps a sticky exception-flag register and a completed-result counter, so software or the control FSM can read them in the style of an FCSR.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 16, width of the completed-result counter

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
in_valid  input  1  core result present this cycle
in_ready  output  1  FIFO can accept; high when not full
Sz  input  1  result sign from add/sub core
Ez  input  8  result biased exponent
Mz  input  23  result fraction (hidden bit excluded)
invalid_flag  input  1  core invalid flag
overflow_flag  input  1  core overflow flag
underflow_flag  input  1  core underflow flag
inexact_flag  input  1  core inexact flag
zero_flag  input  1  core zero flag
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  32  packed word {S,E[7:0],M[22:0]} of head entry
out_flags  output  5  {invalid,overflow,underflow,inexact,zero} of head entry
sticky_flags  output  5  OR-accumulated flags of all accepted results, same order
flags_clr  input  1  clears sticky_flags
result_cnt  output  CNT_W  number of results popped since reset

Behaviour:
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Stored entry is 37 bits: {Sz,Ez,Mz,flags}.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. There is no bypass path.
- out_data and out_flags are driven from the head entry while out_valid=1. They read 0 when the FIFO is empty.
- Occupancy counter is $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- in_ready = (count != DEPTH); out_valid = (count != 0).
- Full boundary: in_valid while full is ignored. Data is dropped at the source because in_ready=0, and the counter does not change.
- Simultaneous push and pop when full: this is not allowed, because in_ready=0. The push is ignored and the pop proceeds.
- Simultaneous push and pop when empty: the push is taken, no pop occurs, and count becomes 1.
- Simultaneous push and pop otherwise: both occur and count is unchanged.
- sticky_flags:
  - On a push, the register ORs in the incoming flags in the same cycle the entry is written.
  - flags_clr has priority over accumulation. If flags_clr and a push occur in the same cycle, the result is exactly the pushed entry's flags, not 0.
- result_cnt: increments by 1 per pop and wraps modulo 2^CNT_W without saturation.
- Reset (RST=1 at edge) clears everything:
  - pointers and count = 0
  - out_valid = 0, in_ready = 1 (combinational from count)
  - out_data = 0, out_flags = 0, sticky_flags = 0, result_cnt = 0
  - FIFO storage does not need clearing.
- Reset mid-transfer discards all queued entries. Inputs during the reset cycle are ignored.
- No state machine beyond the FIFO controller. Its conceptual states are EMPTY, PARTIAL and FULL, derived from count.

Optional Feature:
RESULT_CANON_NAN_EN
- Defined: at push, any entry with Ez==8'hFF and Mz!=0 is stored as the canonical quiet NaN.
  - Value is {1'b0,8'hFF,23'h400000} = 32'h7FC00000.
  - Flags are stored unchanged.
- Undefined: NaN payload and sign pass through unmodified.

Decomposition:
- Package fp_pkg holds:
  - EXP_W=8, MAN_W=23, FLAG_W=5
  - flag bit index constants FLG_INV=4, FLG_OVF=3, FLG_UNF=2, FLG_INX=1, FLG_ZER=0
  - CANON_QNAN=32'h7FC00000
  - a packed struct type for {sign,exp,man} plus a flags type.
- One natural sub-module, fp_result_fifo: a generic synchronous FIFO parameterised on width and depth. The top level adds packing, NaN canonicalisation, sticky flags and the counter.

Test Plan:
- Push Sz=0, Ez=8'h82, Mz=23'h1C0000, flags=0 with out_ready=1. Expect out_valid next cycle, out_data=32'h411C0000, out_flags=0, then result_cnt=1.
- Hold out_ready=0 and push DEPTH=4 results. Expect in_ready=0 after the 4th push, a 5th push ignored, then 4 pops in order with the 5th value absent.
- Push a result with flags 5'b01000 (Ez=8'hFF, Mz=0), then one with 5'b00010. Expect sticky_flags=5'b01010. Assert flags_clr alone and expect 0. Assert flags_clr together with a push of 5'b10000 and expect 5'b10000.
- Push a NaN Ez=8'hFF, Mz=23'h000208, flags=5'b10000:
  - with the macro defined, expect out_data=32'h7FC00000
  - without it, expect 32'h7F800208.
- Fill 2 entries, then assert RST for 1 cycle while in_valid=1. Expect out_valid=0, in_ready=1, count=0, sticky_flags=0, result_cnt=0 the cycle after.
- FIFO half full with continuous push and pop for 20 cycles. Expect count constant, pointers wrapping, and output order equal to input order.
